// File: rtl/seg_scan_driver.sv
// seg_scan_driver: eight-digit multiplexed hex seven-segment driver with per-frame latching.
// Optional SEG_LEADING_ZERO_BLANK_EN blanks digits above the most-significant nonzero nibble.
module seg_scan_driver #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [32:0] data,
    output logic [2:0]  which,
    output logic [7:0]  seg
);
    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    which_q, which_d;
    logic [7:0]    seg_q, seg_d;
    logic [32:0]   frame_q, frame_d;
    logic          pend_q;
    logic          tick;
    logic [3:0]    nib;
    logic [2:0]    top;
    logic          show;

    function automatic logic [7:0] dec(input logic [3:0] n);
        case (n)
            4'h0: dec = 8'hC0;
            4'h1: dec = 8'hF9;
            4'h2: dec = 8'hA4;
            4'h3: dec = 8'hB0;
            4'h4: dec = 8'h99;
            4'h5: dec = 8'h92;
            4'h6: dec = 8'h82;
            4'h7: dec = 8'hF8;
            4'h8: dec = 8'h80;
            4'h9: dec = 8'h90;
            4'hA: dec = 8'h88;
            4'hB: dec = 8'h83;
            4'hC: dec = 8'hC6;
            4'hD: dec = 8'hA1;
            4'hE: dec = 8'h86;
            default: dec = 8'h8E;
        endcase
    endfunction

    // seg is decoded from the next frame/which so both registers update on one edge
    always_comb begin
        tick    = cnt_q == CW'(SCAN_DIV - 1);
        cnt_d   = tick ? '0 : cnt_q + CW'(1);
        which_d = which_q + {2'b00, tick};
        frame_d = (pend_q || (tick && which_q == 3'd7)) ? data : frame_q;
        nib     = 4'(frame_d[32:1] >> {which_d, 2'b00});
        top     = '0;
        for (int i = 1; i < 8; i++)
            if (frame_d[4*i+1 +: 4] != 4'h0) top = 3'(i);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        show    = frame_d[0] && (which_d <= top);
`else
        show    = frame_d[0];
`endif
        seg_d   = show ? dec(nib) : 8'hFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            which_q <= '0;
            seg_q   <= 8'hFF;
            frame_q <= '0;
            pend_q  <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            which_q <= which_d;
            seg_q   <= seg_d;
            frame_q <= frame_d;
            pend_q  <= 1'b0;
        end
    end

    assign which = which_q;
    assign seg   = seg_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: randomized and directed checks of seg_scan_driver against a cycle-count model.
module tb_seg_scan_driver;
    localparam int D = 4;

    logic        clk = 0;
    logic        rst;
    logic [32:0] data;
    logic [2:0]  which;
    logic [7:0]  seg;

    int pass_cnt = 0;
    int total = 0;

    int          n = 0;
    logic [32:0] mframe = '0;
    logic [2:0]  exp_which = '0;
    logic [7:0]  exp_seg = 8'hFF;
    logic [7:0]  dtab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [7:0]  lit [8];

    seg_scan_driver #(.SCAN_DIV(D)) dut (.clk(clk), .rst(rst), .data(data), .which(which), .seg(seg));

    always #5 clk = ~clk;

    function automatic logic [7:0] mseg(input logic [32:0] f, input int k);
        if (!f[0]) return 8'hFF;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        begin
            int top = 0;
            for (int i = 0; i < 8; i++)
                if (((f[32:1] >> (4*i)) & 32'hF) != 0) top = i;
            if (k > top) return 8'hFF;
        end
`endif
        return dtab[int'((f[32:1] >> (4*k)) & 32'hF)];
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (n=%0d)", name, act, exp, n);
    endtask

    task automatic go_to(input int target);
        int lim = 0;
        while (n != target && lim < 2000) begin
            @(negedge clk);
            lim++;
        end
        if (n != target) begin
            total++;
            $display("FAIL go_to: got n=%0d expected %0d", n, target);
        end
    endtask

    // Model: n counts edges since reset release; digit = n/D, frame reloads at n=1 and every 8*D.
    always @(posedge clk) begin
        if (rst) begin
            n = 0;
            mframe = '0;
            exp_which = '0;
            exp_seg = 8'hFF;
        end else begin
            n++;
            if (n == 1 || n % (8*D) == 0) mframe = data;
            exp_which = 3'((n / D) % 8);
            exp_seg = mseg(mframe, int'(exp_which));
        end
    end

    always @(posedge clk) begin
        #1;
        chk("which", {5'b0, which}, {5'b0, exp_which});
        chk("seg", seg, exp_seg);
    end

    initial begin
        rst = 1;
        data = {32'h12345678, 1'b1};
        repeat (3) @(negedge clk);
        chk("rst_which", {5'b0, which}, 8'h00);
        chk("rst_seg", seg, 8'hFF);
        rst = 0;
        go_to(1);
        chk("first_seg", seg, 8'h80);
        chk("first_which", {5'b0, which}, 8'h00);
        go_to(D);
        chk("digit1_which", {5'b0, which}, 8'h01);
        chk("digit1_seg", seg, 8'hF8);
        data = {32'h0123ABCD, 1'b1};
        lit = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
`ifdef SEG_LEADING_ZERO_BLANK_EN
        lit[7] = 8'hFF;
`endif
        for (int k = 0; k < 8; k++) begin
            go_to(8*D + D*k);
            chk("order_which", {5'b0, which}, 8'(k));
            chk("order_seg", seg, lit[k]);
            if (k == 3) data = {32'hFFFFFFFF, 1'b1};
        end
        for (int k = 0; k < 8; k++) begin
            go_to(16*D + D*k);
            chk("newframe_seg", seg, 8'h8E);
            if (k == 0) data = {32'h88888888, 1'b0};
        end
        for (int k = 0; k < 8; k++) begin
            go_to(24*D + D*k);
            chk("invalid_which", {5'b0, which}, 8'(k));
            chk("invalid_seg", seg, 8'hFF);
        end
        for (int i = 0; i < 640; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) data = {$urandom, 1'($urandom_range(0, 3) != 0)};
        end
        go_to(n + ((5*D + 3) - n % (8*D) + 8*D) % (8*D));
        rst = 1;
        data = {32'h00000A05, 1'b1};
        @(negedge clk);
        chk("midrst_which", {5'b0, which}, 8'h00);
        chk("midrst_seg", seg, 8'hFF);
        rst = 0;
        lit = '{8'h92, 8'hC0, 8'h88, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
`ifdef SEG_LEADING_ZERO_BLANK_EN
        for (int k = 3; k < 8; k++) lit[k] = 8'hFF;
`endif
        for (int k = 0; k < 8; k++) begin
            go_to(k == 0 ? 1 : D*k);
            chk("lz_a05_seg", seg, lit[k]);
            if (k == 7) data = {32'h0, 1'b1};
        end
        for (int k = 0; k < 8; k++) begin
            go_to(8*D + D*k);
`ifdef SEG_LEADING_ZERO_BLANK_EN
            chk("lz_zero_seg", seg, k == 0 ? 8'hC0 : 8'hFF);
`else
            chk("lz_zero_seg", seg, 8'hC0);
`endif
        end
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
